// File: rtl/dcache_miss_ctrl.sv
// Load-side data cache controller: hit lookup, MSHR-tracked misses with
// same-block merging, tagged memory returns, cache fill and LSQ responses.
module dcache_miss_ctrl #(
  parameter int NUM_MSHR   = 4,
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 8,
  parameter int ID_BITS    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_req_valid,
  input  logic [63:0]           ld_req_addr,
  input  logic [ID_BITS-1:0]    ld_req_id,
  output logic                  ld_req_ready,
  output logic                  rd_load_en,
  output logic [INDEX_BITS-1:0] rd_idx,
  output logic [TAG_BITS-1:0]   rd_tag,
  input  logic                  rd_valid,
  input  logic [63:0]           rd_data,
  output logic                  fill_en,
  output logic [INDEX_BITS-1:0] fill_idx,
  output logic [TAG_BITS-1:0]   fill_tag,
  output logic [63:0]           fill_data,
  output logic [1:0]            proc2mem_command,
  output logic [63:0]           proc2mem_addr,
  input  logic                  mem_grant,
  input  logic [3:0]            mem2proc_response,
  input  logic [3:0]            mem2proc_tag,
  input  logic [63:0]           mem2proc_data,
  output logic                  ld_resp_valid,
  output logic [ID_BITS-1:0]    ld_resp_id,
  output logic [63:0]           ld_resp_data,
  output logic                  mshr_full
);
  localparam int SEL_BITS = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam int BLK_BITS = TAG_BITS + INDEX_BITS + 3;

  typedef enum logic [2:0] {FREE, ISSUE, WAIT_MEM, MERGED, DONE} entry_state_e;

  entry_state_e          state      [NUM_MSHR];
  entry_state_e          state_next [NUM_MSHR];
  logic [ID_BITS-1:0]    ent_id      [NUM_MSHR];
  logic [INDEX_BITS-1:0] ent_idx     [NUM_MSHR];
  logic [TAG_BITS-1:0]   ent_tag     [NUM_MSHR];
  logic [3:0]            ent_mem_tag [NUM_MSHR];
  logic [63:0]           ent_data    [NUM_MSHR];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  any_free, any_issue, any_fill, any_done;
  logic [SEL_BITS-1:0]   free_sel, issue_sel, fill_sel, done_sel;
  logic                  req_dup, fill_dup;
  logic                  accept, hit, alloc, issue_ok;
  logic [NUM_MSHR-1:0]   capture;
  logic                  unused_addr_bits;

  assign req_idx  = ld_req_addr[INDEX_BITS+2:3];
  assign req_tag  = ld_req_addr[TAG_BITS+INDEX_BITS+2:INDEX_BITS+3];
  assign unused_addr_bits = ^{ld_req_addr[63:BLK_BITS], ld_req_addr[2:0]};

  assign accept   = ld_req_valid && any_free;
  assign hit      = accept && rd_valid;
  assign alloc    = accept && !rd_valid;
  assign issue_ok = any_issue && mem_grant && (mem2proc_response != 4'd0);
  assign fill_dup = any_fill && (ent_idx[fill_sel] == req_idx) && (ent_tag[fill_sel] == req_tag);

  // Lowest-index priority pick for each role, plus the merge probe.
  always_comb begin
    any_free  = 1'b0; free_sel  = '0;
    any_issue = 1'b0; issue_sel = '0;
    any_fill  = 1'b0; fill_sel  = '0;
    any_done  = 1'b0; done_sel  = '0;
    req_dup   = 1'b0;
    for (int unsigned i = 0; i < NUM_MSHR; i++) begin
      if (state[i] == FREE && !any_free) begin
        any_free = 1'b1; free_sel = SEL_BITS'(i);
      end
      if (state[i] == ISSUE && !any_issue) begin
        any_issue = 1'b1; issue_sel = SEL_BITS'(i);
      end
      if (state[i] == WAIT_MEM && mem2proc_tag != 4'd0 &&
          ent_mem_tag[i] == mem2proc_tag && !any_fill) begin
        any_fill = 1'b1; fill_sel = SEL_BITS'(i);
      end
      if (state[i] == DONE && !any_done) begin
        any_done = 1'b1; done_sel = SEL_BITS'(i);
      end
      if ((state[i] == ISSUE || state[i] == WAIT_MEM) &&
          ent_idx[i] == req_idx && ent_tag[i] == req_tag)
        req_dup = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_MSHR; i++) begin
      state_next[i] = state[i];
      capture[i]    = 1'b0;
    end
    if (issue_ok) state_next[issue_sel] = WAIT_MEM;
    if (any_fill) begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
        if (SEL_BITS'(i) == fill_sel ||
            (state[i] == MERGED && ent_idx[i] == ent_idx[fill_sel] &&
             ent_tag[i] == ent_tag[fill_sel])) begin
          state_next[i] = DONE;
          capture[i]    = 1'b1;
        end
      end
    end
    // A merge into the block being filled this cycle completes immediately.
    if (alloc) begin
      if (!req_dup) begin
        state_next[free_sel] = ISSUE;
      end else if (fill_dup) begin
        state_next[free_sel] = DONE;
        capture[free_sel]    = 1'b1;
      end else begin
        state_next[free_sel] = MERGED;
      end
    end
    if (!hit && any_done) state_next[done_sel] = FREE;
  end

  always_comb begin
    ld_req_ready     = any_free;
    mshr_full        = !any_free;
    rd_load_en       = accept;
    rd_idx           = req_idx;
    rd_tag           = req_tag;
    proc2mem_command = any_issue ? 2'd1 : 2'd0;
    proc2mem_addr    = '0;
    if (any_issue)
      proc2mem_addr[BLK_BITS-1:0] = {ent_tag[issue_sel], ent_idx[issue_sel], 3'b000};
    fill_en   = any_fill;
    fill_idx  = any_fill ? ent_idx[fill_sel] : '0;
    fill_tag  = any_fill ? ent_tag[fill_sel] : '0;
    fill_data = any_fill ? mem2proc_data : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) state[i] <= FREE;
      ld_resp_valid <= 1'b0;
      ld_resp_id    <= '0;
      ld_resp_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
        state[i] <= state_next[i];
        if (capture[i]) ent_data[i] <= mem2proc_data;
      end
      if (alloc) begin
        ent_id[free_sel]  <= ld_req_id;
        ent_idx[free_sel] <= req_idx;
        ent_tag[free_sel] <= req_tag;
      end
      if (issue_ok) ent_mem_tag[issue_sel] <= mem2proc_response;
      if (hit) begin
        ld_resp_valid <= 1'b1;
        ld_resp_id    <= ld_req_id;
        ld_resp_data  <= rd_data;
      end else if (any_done) begin
        ld_resp_valid <= 1'b1;
        ld_resp_id    <= ent_id[done_sel];
        ld_resp_data  <= ent_data[done_sel];
      end else begin
        ld_resp_valid <= 1'b0;
      end
    end
  end
endmodule
